triangle_bbox_scanner: RTL and testbench



---
 rtl/triangle_bbox_scanner.sv | 96 +++++++++
 tb/tb_triangle_bbox_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_bbox_scanner.sv
// Clips one triangle bounding box to the screen, then walks its pixels in raster
// order. Pixels are emitted one per cycle over a valid/ready handshake.
module triangle_bbox_scanner #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic             aClock,
  input  logic             aReset,
  input  logic [1:0][10:0] aMin,
  input  logic [1:0][10:0] aMax,
  input  logic             aBoxValid,
  output logic             anOutBoxReady,
  output logic [1:0][10:0] anOutPixel,
  output logic             anOutPixelValid,
  input  logic             aPixelReady,
  output logic             anOutLastPixel,
  output logic             anOutBoxDone
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [10:0] XLIM = 11'(SCREEN_WIDTH - 1);
  localparam logic [10:0] YLIM = 11'(SCREEN_HEIGHT - 1);

  function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t      state;
  logic [10:0] x, y;
  logic [10:0] cx0, cx1, cy0, cy1;
  logic        done;

  logic [10:0] clip_x1, clip_y1;
  logic        empty, accept, handshake, at_end_x, at_end_y;

  always_comb begin
    clip_x1   = clamp(aMax[0], XLIM);
    clip_y1   = clamp(aMax[1], YLIM);
    empty     = (aMin[0] > clip_x1) || (aMin[1] > clip_y1);
    accept    = (state == IDLE) && aBoxValid;
    handshake = (state == SCAN) && aPixelReady;
    at_end_x  = (x == cx1);
    at_end_y  = (y == cy1);
  end

  // Control and the pixel cursor; the cursor reads (0,0) after reset.
  always_ff @(posedge aClock) begin
    if (aReset) begin
      state <= IDLE;
      done  <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (empty) begin
            done <= 1'b1;
          end else begin
            x     <= aMin[0];
            y     <= aMin[1];
            state <= SCAN;
          end
        end
      end else if (handshake) begin
        if (!at_end_x) begin
          x <= x + 11'd1;
        end else if (!at_end_y) begin
          x <= cx0;
          y <= y + 11'd1;
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  // Clipped box bounds are pure data, captured only when a non-empty box is taken.
  always_ff @(posedge aClock) begin
    if (accept && !empty) begin
      cx0 <= aMin[0];
      cy0 <= aMin[1];
      cx1 <= clip_x1;
      cy1 <= clip_y1;
    end
  end

  assign anOutBoxReady   = (state == IDLE) && !aReset;
  assign anOutPixelValid = (state == SCAN);
  assign anOutPixel      = {y, x};
  assign anOutLastPixel  = (state == SCAN) && at_end_x && at_end_y;
  assign anOutBoxDone    = done;

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Bench for triangle_bbox_scanner: table of boxes, hand-written corner sequences,
// and random boxes with random backpressure against a raster-order pixel model.
module tb_triangle_bbox_scanner;

  logic             aClock = 1'b0;
  logic             aReset;
  logic [1:0][10:0] aMin, aMax;
  logic             aBoxValid;
  logic             anOutBoxReady;
  logic [1:0][10:0] anOutPixel;
  logic             anOutPixelValid;
  logic             aPixelReady;
  logic             anOutLastPixel;
  logic             anOutBoxDone;

  triangle_bbox_scanner #(.SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)) dut (
    .aClock(aClock), .aReset(aReset), .aMin(aMin), .aMax(aMax),
    .aBoxValid(aBoxValid), .anOutBoxReady(anOutBoxReady),
    .anOutPixel(anOutPixel), .anOutPixelValid(anOutPixelValid),
    .aPixelReady(aPixelReady), .anOutLastPixel(anOutLastPixel),
    .anOutBoxDone(anOutBoxDone)
  );

  always #5 aClock = ~aClock;

  int n_total = 0;
  int n_pass  = 0;
  logic [21:0] expq[$];
  logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [10:0] mnx, mny, mxx, mxy;
    int          cnt;
    logic [21:0] first_px, last_px;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: clip to 640x480, then every pixel once, x inner, y outer.
  task automatic build_model(input int mnx, mny, mxx, mxy);
    int x1, y1;
    x1 = (mxx > 639) ? 639 : mxx;
    y1 = (mxy > 479) ? 479 : mxy;
    for (int yy = mny; yy <= y1; yy++)
      for (int xx = mnx; xx <= x1; xx++)
        expq.push_back({11'(yy), 11'(xx)});
  endtask

  task automatic step;
    @(posedge aClock); #1;
  endtask

  task automatic accept_box(input logic [10:0] a, b, c, d);
    chk("box_ready_before_accept", 32'(anOutBoxReady), 32'd1);
    aMin[0] = a; aMin[1] = b; aMax[0] = c; aMax[1] = d;
    aBoxValid = 1'b1;
    step();
    aBoxValid = 1'b0;
    aMin = 22'($urandom);
    aMax = 22'($urandom);
  endtask

  // Starts in the cycle after accept; ends in the done cycle.
  task automatic run_scan(input int mode, output int hs_cnt,
                          output logic [21:0] first_px, last_px);
    int idx = 0;
    int cyc = 0;
    int k = 0;
    logic hs;
    hs_cnt = 0; first_px = '0; last_px = '0;
    while (idx < expq.size() && cyc < 5000) begin
      chk("pix_valid", 32'(anOutPixelValid), 32'd1);
      chk("pix_value", 32'(anOutPixel), 32'(expq[idx]));
      chk("pix_last", 32'(anOutLastPixel), 32'(idx == expq.size() - 1));
      chk("ready_busy", 32'(anOutBoxReady), 32'd0);
      chk("done_busy", 32'(anOutBoxDone), 32'd0);
      if (mode == 0) hs = 1'b1;
      else if (mode == 1) hs = 1'($urandom_range(0, 1));
      else hs = (k < 7) ? pat[k] : 1'b1;
      aPixelReady = hs;
      k++;
      if (hs) begin
        if (idx == 0) first_px = anOutPixel;
        last_px = anOutPixel;
        hs_cnt++;
        idx++;
      end
      step();
      cyc++;
    end
    if (idx < expq.size()) chk("scan_timeout", 32'(idx), 32'(expq.size()));
    chk("done_pulse", 32'(anOutBoxDone), 32'd1);
    chk("ready_after_box", 32'(anOutBoxReady), 32'd1);
    chk("valid_after_box", 32'(anOutPixelValid), 32'd0);
  endtask

  task automatic run_box(input logic [10:0] a, b, c, d, input int mode,
                         output int hs_cnt, output logic [21:0] first_px, last_px);
    expq.delete();
    build_model(int'(a), int'(b), int'(c), int'(d));
    accept_box(a, b, c, d);
    if (expq.size() == 0) begin
      hs_cnt = 0; first_px = '0; last_px = '0;
      chk("empty_valid", 32'(anOutPixelValid), 32'd0);
      chk("empty_done", 32'(anOutBoxDone), 32'd1);
      chk("empty_ready", 32'(anOutBoxReady), 32'd1);
    end else begin
      run_scan(mode, hs_cnt, first_px, last_px);
    end
    aPixelReady = 1'b0;
    step();
    chk("done_one_cycle", 32'(anOutBoxDone), 32'd0);
  endtask

  vec_t vecs[7];
  int cnt;
  logic [21:0] fp, lp;

  initial begin
    vecs[0] = '{11'd2,   11'd3,   11'd4,    11'd4,    6,   {11'd3, 11'd2},     {11'd4, 11'd4}};
    vecs[1] = '{11'd10,  11'd10,  11'd10,   11'd10,   1,   {11'd10, 11'd10},   {11'd10, 11'd10}};
    vecs[2] = '{11'd636, 11'd478, 11'd700,  11'd900,  8,   {11'd478, 11'd636}, {11'd479, 11'd639}};
    vecs[3] = '{11'd650, 11'd0,   11'd700,  11'd10,   0,   22'd0,              22'd0};
    vecs[4] = '{11'd5,   11'd5,   11'd3,    11'd9,    0,   22'd0,              22'd0};
    vecs[5] = '{11'd639, 11'd479, 11'd2047, 11'd2047, 1,   {11'd479, 11'd639}, {11'd479, 11'd639}};
    vecs[6] = '{11'd0,   11'd0,   11'd0,    11'd479,  480, {11'd0, 11'd0},     {11'd479, 11'd0}};

    aReset = 1'b1; aBoxValid = 1'b0; aPixelReady = 1'b0; aMin = '0; aMax = '0;
    step(); step();
    chk("rst_valid", 32'(anOutPixelValid), 32'd0);
    chk("rst_last", 32'(anOutLastPixel), 32'd0);
    chk("rst_done", 32'(anOutBoxDone), 32'd0);
    chk("rst_pixel", 32'(anOutPixel), 32'd0);
    chk("rst_ready", 32'(anOutBoxReady), 32'd0);
    aReset = 1'b0;
    step();
    chk("ready_after_release", 32'(anOutBoxReady), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_box(vecs[i].mnx, vecs[i].mny, vecs[i].mxx, vecs[i].mxy, 0, cnt, fp, lp);
      chk("tbl_count", 32'(cnt), 32'(vecs[i].cnt));
      if (vecs[i].cnt > 0) begin
        chk("tbl_first", 32'(fp), 32'(vecs[i].first_px));
        chk("tbl_last", 32'(lp), 32'(vecs[i].last_px));
      end
    end

    // Backpressure with the pattern 1,0,0,1,1,0,1.
    run_box(11'd0, 11'd0, 11'd1, 11'd1, 2, cnt, fp, lp);
    chk("bp_handshakes", 32'(cnt), 32'd4);

    // Back-to-back: second box waits on the pins with valid held high.
    expq.delete();
    build_model(20, 30, 21, 30);
    aMin[0] = 11'd20; aMin[1] = 11'd30; aMax[0] = 11'd21; aMax[1] = 11'd30;
    aBoxValid = 1'b1;
    step();
    aMin[0] = 11'd100; aMin[1] = 11'd200; aMax[0] = 11'd101; aMax[1] = 11'd201;
    run_scan(0, cnt, fp, lp);
    chk("b2b_first_count", 32'(cnt), 32'd2);
    step();
    aBoxValid = 1'b0;
    expq.delete();
    build_model(100, 200, 101, 201);
    run_scan(0, cnt, fp, lp);
    chk("b2b_second_count", 32'(cnt), 32'd4);
    chk("b2b_second_first", 32'(fp), 32'({11'd200, 11'd100}));
    aPixelReady = 1'b0;
    step();
    chk("b2b_done_clear", 32'(anOutBoxDone), 32'd0);

    // Reset during the 3rd pixel of a 4x4 box.
    expq.delete();
    build_model(0, 0, 3, 3);
    accept_box(11'd0, 11'd0, 11'd3, 11'd3);
    aPixelReady = 1'b1;
    step(); step();
    chk("rst_mid_pixel3", 32'(anOutPixel), 32'({11'd0, 11'd2}));
    aReset = 1'b1;
    step();
    chk("rst_mid_valid", 32'(anOutPixelValid), 32'd0);
    chk("rst_mid_done", 32'(anOutBoxDone), 32'd0);
    chk("rst_mid_pixel", 32'(anOutPixel), 32'd0);
    chk("rst_mid_last", 32'(anOutLastPixel), 32'd0);
    aReset = 1'b0; aPixelReady = 1'b0;
    step();
    chk("rst_mid_ready", 32'(anOutBoxReady), 32'd1);
    chk("rst_mid_no_done", 32'(anOutBoxDone), 32'd0);
    run_box(11'd7, 11'd8, 11'd9, 11'd9, 0, cnt, fp, lp);
    chk("fresh_first", 32'(fp), 32'({11'd8, 11'd7}));
    chk("fresh_count", 32'(cnt), 32'd6);

    // Random boxes near and across the screen edges, random backpressure.
    for (int i = 0; i < 40; i++) begin
      int a, b, c, d;
      a = $urandom_range(0, 700);
      b = $urandom_range(0, 540);
      c = a + $urandom_range(0, 6) - 1;
      d = b + $urandom_range(0, 5) - 1;
      if (c < 0) c = 0;
      if (d < 0) d = 0;
      run_box(11'(a), 11'(b), 11'(c), 11'(d), 1, cnt, fp, lp);
      chk("rand_count", 32'(cnt), 32'(expq.size()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_total);
    $fatal(1);
  end

endmodule
